rx_frame_ctrl: RTL and testbench
================================

Name: rx_frame_ctrl

Overview:
- Sequences one 5B/4B serial receiver channel: drives its rx enable, collects its decoded byte stream into an external frame buffer, and enforces length and inter-byte timeout.
- Re-arms the receiver after any error, then hands complete frames to the bus logic via a valid/ack handshake.
- Sits between the per-channel receiver (rdy/frame/data/done outputs) and the frame buffer RAM plus bus protocol layer.

Parameters:
- MAX_LEN, 64, maximum bytes per frame (1..127).
- ADDR_W, 6, buffer address width; 2**ADDR_W >= MAX_LEN.
- TIMEOUT, 2000, max clk cycles between byte events while a frame is open (< 65536).
- REARM_CYC, 4, cycles rx_en is held low during re-arm (>= 1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- enable  in  1  controller enable from config register.
- rx_rdy  in  1  receiver byte strobe, 1-cycle pulse.
- rx_frame  in  1  receiver frame-open level.
- rx_data  in  8  receiver decoded byte, valid with rx_rdy.
- rx_done  in  1  receiver end-of-frame (TT) pulse.
- rx_en  out  1  receiver enable.
- buf_we  out  1  buffer write strobe.
- buf_addr  out  ADDR_W  buffer write address.
- buf_wdata  out  8  buffer write data.
- frm_valid  out  1  complete frame available in buffer.
- frm_len  out  7  byte count of presented frame.
- frm_ack  in  1  consumer has taken the frame.
- err_cnt  out  8  saturating error counter.
- err_last  out  2  last error cause: 0 none, 1 overflow, 2 timeout, 3 abort.

Behaviour:
- Reset (reset_n=0 at a clk edge): state IDLE; rx_en=0, buf_we=0, buf_addr=0, buf_wdata=0, frm_valid=0, frm_len=0, err_cnt=0, err_last=0; byte and timer counters cleared. Reset mid-frame discards everything.
- States: IDLE, ARMED, RECV, HOLD, REARM.
- IDLE: rx_en=0. enable=1 -> ARMED.
- ARMED: rx_en=1, byte count=0.
  - rising rx_frame -> RECV, timer cleared.
  - enable=0 -> IDLE.
- RECV: rx_en=1.
  - Each rx_rdy, count<MAX_LEN: next cycle buf_we=1 (one cycle), buf_addr=count, buf_wdata=rx_data; count+1; timer cleared.
  - rx_rdy with count==MAX_LEN: overflow error.
  - rx_done with count>=1: next cycle frm_valid=1, frm_len=count -> HOLD.
  - rx_done with count==0: empty frame, silently discarded (no error) -> ARMED.
  - rx_frame falls without rx_done in the same cycle: abort error.
  - Timer reaches TIMEOUT with no rx_rdy/rx_done: timeout error.
  - rx_rdy and rx_done in the same cycle: write the byte first; frm_len includes it.
  - enable=0 -> IDLE; partial frame discarded, no error counted.
- HOLD: rx_en=0, so frames arriving here are lost.
  - frm_valid and frm_len stay stable until frm_ack.
  - frm_ack=1: frm_valid=0 next cycle -> REARM.
  - enable ignored until ack.
  - frm_ack outside HOLD is ignored.
- REARM: rx_en=0 for exactly REARM_CYC cycles, forcing the receiver FSM to idle and releasing phase lock. Then ARMED if enable=1, else IDLE.
- Error (any of the three): -> REARM next cycle; err_cnt+1, saturating at 255; err_last=cause. Error priority when coincident: overflow > abort > timeout.
- Timer: 16-bit, counts only in RECV, cleared on state entry.
- buf_addr wraps never, because count is bounded by MAX_LEN.

Optional Feature:
- Macro RXC_CHKSUM_EN.
- Defined: on rx_done with count>=2, the XOR of all received bytes (including the final checksum byte) must be 0x00.
  - Nonzero XOR: frame dropped, err_last=3 (abort code reused), err_cnt+1, -> REARM.
  - Valid frame: frm_len excludes the checksum byte.
  - count==1 is treated as a checksum error.
- Undefined: no checksum logic; all frames with count>=1 are presented with the full length.

Test Plan:
- Bytes 0x12,0x34,0x56 then rx_done -> buf writes at addr 0,1,2 with those data; frm_valid=1 one cycle after done; frm_len=3; rx_en=0 until frm_ack; then rx_en low 4 cycles, then 1.
- MAX_LEN=64, 65 rx_rdy pulses -> 64 writes, err_cnt=1, err_last=1, rx_en low 4 cycles, no frm_valid.
- rx_frame rises, one byte, then silence 2000 cycles -> err_last=2, err_cnt=1, state ARMED after re-arm.
- rx_frame falls after 2 bytes with no rx_done -> err_last=3, REARM; rx_done with 0 bytes -> no frm_valid, err_cnt unchanged.
- reset_n=0 for one cycle mid-RECV -> all outputs at reset values next cycle; enable=0 in RECV -> IDLE, rx_en=0, err_cnt unchanged.
- RXC_CHKSUM_EN: bytes 0xA5,0x5A,0xFF then done -> frm_len=2; bytes 0xA5,0x5A,0x00 then done -> dropped, err_cnt+1.

Source files
------------

// File: rtl/rx_frame_ctrl.sv
// Frame sequencer for one 5B/4B receive channel: arms the receiver, writes bytes to the frame buffer, and hands frames over with valid/ack.
// Optional build macro RXC_CHKSUM_EN: the frame must XOR to 0x00 and the trailing checksum byte is left out of frm_len.
module rx_frame_ctrl #(
  parameter int MAX_LEN   = 64,
  parameter int ADDR_W    = 6,
  parameter int TIMEOUT   = 2000,
  parameter int REARM_CYC = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              rx_rdy,
  input  logic              rx_frame,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              rx_en,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_wdata,
  output logic              frm_valid,
  output logic [6:0]        frm_len,
  input  logic              frm_ack,
  output logic [7:0]        err_cnt,
  output logic [1:0]        err_last
);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_RECV, S_HOLD, S_REARM} state_t;

  state_t      state, nxt;
  logic        frame_p0;
  logic [6:0]  byte_cnt;
  logic [15:0] timer;
  logic [15:0] rearm_cnt;

  logic        in_recv, wr_ok, ovf_ev, abort_ev, tmo_ev, done_ev;
  logic        sum_bad, err_ev, frame_ok, empty_ev, stay_recv;
  logic [6:0]  cnt_eff, pres_len;
  logic [1:0]  err_cause;

  // A byte strobe coinciding with rx_done is counted before the frame closes.
  assign in_recv  = (state == S_RECV);
  assign wr_ok    = in_recv && rx_rdy && (byte_cnt < 7'(MAX_LEN));
  assign ovf_ev   = in_recv && rx_rdy && (byte_cnt == 7'(MAX_LEN));
  assign abort_ev = in_recv && frame_p0 && !rx_frame && !rx_done;
  assign tmo_ev   = in_recv && (timer == 16'(TIMEOUT)) && !rx_rdy && !rx_done;
  assign done_ev  = in_recv && rx_done && !ovf_ev;
  assign cnt_eff  = byte_cnt + 7'(wr_ok);

`ifdef RXC_CHKSUM_EN
  logic [7:0] xor_acc, xor_eff;

  assign xor_eff  = xor_acc ^ (wr_ok ? rx_data : 8'h00);
  assign sum_bad  = done_ev && (cnt_eff != 7'd0) &&
                    ((cnt_eff == 7'd1) || (xor_eff != 8'h00));
  assign pres_len = cnt_eff - 7'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) xor_acc <= 8'h00;
    else          xor_acc <= stay_recv ? xor_eff : 8'h00;
  end
`else
  assign sum_bad  = 1'b0;
  assign pres_len = cnt_eff;
`endif

  // Disabling mid-frame is a silent discard, so enable gates every error.
  assign err_ev    = enable && (ovf_ev || abort_ev || tmo_ev || sum_bad);
  assign frame_ok  = enable && done_ev && (cnt_eff != 7'd0) && !sum_bad;
  assign empty_ev  = enable && done_ev && (cnt_eff == 7'd0);
  assign err_cause = ovf_ev ? 2'd1 : ((abort_ev || sum_bad) ? 2'd3 : 2'd2);
  assign stay_recv = in_recv && (nxt == S_RECV);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (enable) nxt = S_ARMED;
      S_ARMED: begin
        if (!enable)                   nxt = S_IDLE;
        else if (rx_frame && !frame_p0) nxt = S_RECV;
      end
      S_RECV: begin
        if (!enable)       nxt = S_IDLE;
        else if (err_ev)   nxt = S_REARM;
        else if (frame_ok) nxt = S_HOLD;
        else if (empty_ev) nxt = S_ARMED;
      end
      S_HOLD:  if (frm_ack) nxt = S_REARM;
      S_REARM: if (rearm_cnt == 16'(REARM_CYC - 1)) nxt = enable ? S_ARMED : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rx_en = 1'b0;
    case (state)
      S_ARMED, S_RECV: rx_en = 1'b1;
      default:         rx_en = 1'b0;
    endcase
  end

  // Registered stage: buffer write port, counters, frame presentation and error log.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_p0  <= 1'b0;
      byte_cnt  <= 7'd0;
      timer     <= 16'd0;
      rearm_cnt <= 16'd0;
      buf_we    <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= 8'h00;
      frm_valid <= 1'b0;
      frm_len   <= 7'd0;
      err_cnt   <= 8'd0;
      err_last  <= 2'd0;
    end else begin
      frame_p0  <= rx_frame;
      byte_cnt  <= stay_recv ? cnt_eff : 7'd0;
      timer     <= stay_recv ? (rx_rdy ? 16'd0 : timer + 16'd1) : 16'd0;
      rearm_cnt <= (state == S_REARM) ? rearm_cnt + 16'd1 : 16'd0;
      buf_we    <= wr_ok;
      if (wr_ok) begin
        buf_addr  <= ADDR_W'(byte_cnt);
        buf_wdata <= rx_data;
      end
      if (in_recv && frame_ok) begin
        frm_valid <= 1'b1;
        frm_len   <= pres_len;
      end else if ((state == S_HOLD) && frm_ack) begin
        frm_valid <= 1'b0;
      end
      if (in_recv && err_ev) begin
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        err_last <= err_cause;
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Scoreboard bench for rx_frame_ctrl: directed frames push expected writes, frames and errors; a monitor pops and compares.
`timescale 1ns/1ps
module tb_rx_frame_ctrl;
  localparam int MAX_LEN   = 64;
  localparam int ADDR_W    = 6;
  localparam int TIMEOUT   = 2000;
  localparam int REARM_CYC = 4;

`ifdef RXC_CHKSUM_EN
  localparam logic [7:0] T1_B3 = 8'h26;
  localparam int         T1_LEN = 2;
  localparam logic [7:0] T2_B2 = 8'h01;
  localparam int         T2_LEN = 1;
`else
  localparam logic [7:0] T1_B3 = 8'hB3;
  localparam int         T1_LEN = 3;
  localparam logic [7:0] T2_B2 = 8'h02;
  localparam int         T2_LEN = 2;
`endif

  logic clk = 1'b0;
  logic reset_n, enable, rx_rdy, rx_frame, rx_done, frm_ack;
  logic [7:0] rx_data;
  logic rx_en, buf_we, frm_valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0] buf_wdata, err_cnt;
  logic [6:0] frm_len;
  logic [1:0] err_last;

  rx_frame_ctrl #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .REARM_CYC(REARM_CYC)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .rx_rdy(rx_rdy), .rx_frame(rx_frame),
    .rx_data(rx_data), .rx_done(rx_done), .rx_en(rx_en), .buf_we(buf_we), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata), .frm_valid(frm_valid), .frm_len(frm_len), .frm_ack(frm_ack),
    .err_cnt(err_cnt), .err_last(err_last)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [7:0] c; logic [1:0] l; } er_t;
  wr_t wq[$];
  int  fq[$];
  er_t eq[$];
  int  checks = 0;
  int  errors = 0;
  int  nwr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    wr_t w;
    w.a = ADDR_W'(nwr);
    w.d = b;
    wq.push_back(w);
    nwr++;
    rx_data = b;
    rx_rdy  = 1'b1;
    tick(1);
    rx_rdy  = 1'b0;
    tick(1);
  endtask

  task automatic push_err(input logic [7:0] c, input logic [1:0] l);
    er_t e;
    e.c = c;
    e.l = l;
    eq.push_back(e);
  endtask

  task automatic open_frame();
    nwr = 0;
    rx_frame = 1'b1;
    tick(1);
  endtask

  task automatic rearm_len(output int n);
    n = 0;
    while (rx_en == 1'b0 && n < 50) begin
      n++;
      tick(1);
    end
  endtask

  task automatic ack_frame();
    int n;
    frm_ack = 1'b1;
    tick(1);
    frm_ack = 1'b0;
    chk("valid_after_ack", frm_valid, 0);
    rearm_len(n);
    chk("rearm_after_ack", n, REARM_CYC);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_en"}, rx_en, 0);
    chk({tag, "_buf_we"}, buf_we, 0);
    chk({tag, "_buf_addr"}, buf_addr, 0);
    chk({tag, "_buf_wdata"}, buf_wdata, 0);
    chk({tag, "_frm_valid"}, frm_valid, 0);
    chk({tag, "_frm_len"}, frm_len, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_err_last"}, err_last, 0);
  endtask

  // Monitor samples 2 ns after the active edge; inputs only move on the falling edge.
  logic       fv_prev;
  logic [7:0] err_prev;
  always @(posedge clk) begin
    wr_t w;
    er_t e;
    #2;
    if (!reset_n) begin
      fv_prev  = 1'b0;
      err_prev = err_cnt;
    end else begin
      if (buf_we) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", buf_addr, buf_wdata);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", buf_addr, w.a);
          chk("wr_data", buf_wdata, w.d);
        end
      end
      if (frm_valid && !fv_prev) begin
        if (fq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame: len %0d, none expected", frm_len);
        end else begin
          chk("frm_len", frm_len, fq.pop_front());
        end
      end
      if (err_cnt != err_prev) begin
        if (eq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_error: err_cnt %0d err_last %0d, none expected", err_cnt, err_last);
        end else begin
          e = eq.pop_front();
          chk("err_cnt", err_cnt, e.c);
          chk("err_last", err_last, e.l);
        end
      end
      fv_prev  = frm_valid;
      err_prev = err_cnt;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0; enable = 1'b0; rx_rdy = 1'b0; rx_frame = 1'b0;
    rx_done = 1'b0; frm_ack = 1'b0; rx_data = 8'h00;
    tick(3);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick(2);
    chk("idle_rx_en", rx_en, 0);
    enable = 1'b1;
    tick(1);
    chk("armed_rx_en", rx_en, 1);

    // Basic frame, then HOLD ignoring enable until ack.
    open_frame();
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(T1_B3);
    rx_done = 1'b1;
    fq.push_back(T1_LEN);
    tick(1);
    rx_done = 1'b0; rx_frame = 1'b0;
    chk("t1_valid", frm_valid, 1);
    chk("t1_len_now", frm_len, T1_LEN);
    chk("t1_hold_rx_en", rx_en, 0);
    enable = 1'b0;
    tick(5);
    chk("t1_hold_valid", frm_valid, 1);
    chk("t1_hold_len", frm_len, T1_LEN);
    chk("t1_hold_rx_en2", rx_en, 0);
    enable = 1'b1;
    ack_frame();

    // Byte and done in the same cycle.
    open_frame();
    send_byte(8'h01);
    begin
      wr_t w;
      w.a = ADDR_W'(1);
      w.d = T2_B2;
      wq.push_back(w);
    end
    rx_data = T2_B2; rx_rdy = 1'b1; rx_done = 1'b1;
    fq.push_back(T2_LEN);
    tick(1);
    rx_rdy = 1'b0; rx_done = 1'b0; rx_frame = 1'b0;
    chk("t2_valid", frm_valid, 1);
    ack_frame();

    // Overflow: MAX_LEN writes, the extra strobe errors out.
    open_frame();
    for (int i = 0; i < MAX_LEN; i++) send_byte(8'(i * 3 + 1));
    rx_data = 8'hFF; rx_rdy = 1'b1;
    push_err(8'd1, 2'd1);
    tick(1);
    rx_rdy = 1'b0;
    chk("ovf_rx_en", rx_en, 0);
    rearm_len(n);
    chk("ovf_rearm", n, REARM_CYC);
    chk("ovf_err_cnt", err_cnt, 1);
    chk("ovf_err_last", err_last, 1);
    rx_frame = 1'b0;
    tick(1);

    // Timeout after one byte of silence.
    open_frame();
    send_byte(8'hC3);
    push_err(8'd2, 2'd2);
    n = 0;
    while (err_cnt == 8'd1 && n < TIMEOUT + 100) begin
      n++;
      tick(1);
    end
    chk("tmo_window", (n >= TIMEOUT - 2) && (n <= TIMEOUT + 2), 1);
    chk("tmo_err_last", err_last, 2);
    rearm_len(n);
    chk("tmo_rearm", n, REARM_CYC);
    chk("tmo_armed", rx_en, 1);
    rx_frame = 1'b0;
    tick(1);

    // Abort, then an empty frame that is silently dropped.
    open_frame();
    send_byte(8'h9A);
    send_byte(8'hBC);
    rx_frame = 1'b0;
    push_err(8'd3, 2'd3);
    tick(1);
    chk("abort_rx_en", rx_en, 0);
    rearm_len(n);
    chk("abort_rearm", n, REARM_CYC);
    rx_frame = 1'b1;
    tick(1);
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0; rx_frame = 1'b0;
    chk("empty_rx_en", rx_en, 1);
    chk("empty_valid", frm_valid, 0);
    chk("empty_err_cnt", err_cnt, 3);
    tick(2);

    // Reset mid-frame.
    open_frame();
    send_byte(8'h77);
    reset_n = 1'b0; rx_frame = 1'b0;
    tick(1);
    check_reset_outputs("midrst");
    reset_n = 1'b1;
    tick(1);
    chk("rst_rearmed", rx_en, 1);

    // Disable mid-frame.
    open_frame();
    send_byte(8'h88);
    enable = 1'b0;
    tick(1);
    chk("dis_rx_en", rx_en, 0);
    tick(3);
    chk("dis_idle", rx_en, 0);
    chk("dis_err_cnt", err_cnt, 0);
    chk("dis_valid", frm_valid, 0);
    rx_frame = 1'b0; enable = 1'b1;
    tick(2);

`ifdef RXC_CHKSUM_EN
    open_frame();
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_byte(8'hFF);
    rx_done = 1'b1;
    fq.push_back(2);
    tick(1);
    rx_done = 1'b0; rx_frame = 1'b0;
    chk("cks_valid", frm_valid, 1);
    ack_frame();
    open_frame();
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_byte(8'h00);
    rx_done = 1'b1;
    push_err(8'd1, 2'd3);
    tick(1);
    rx_done = 1'b0; rx_frame = 1'b0;
    chk("cks_bad_valid", frm_valid, 0);
    rearm_len(n);
    chk("cks_bad_rearm", n, REARM_CYC);
    chk("cks_bad_err_cnt", err_cnt, 1);
`endif

    tick(5);
    chk("wq_drained", wq.size(), 0);
    chk("fq_drained", fq.size(), 0);
    chk("eq_drained", eq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
